// File: rtl/demux16_router.sv
// Registered 1-to-N word demultiplexer with per-channel valid/ready holding registers.
// Optional broadcast mode (in_bcast port) is enabled by defining DEMUX_BROADCAST_EN.
module demux16_router #(
  parameter int WIDTH = 16,
  parameter int N_OUT = 4,
  parameter int SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
`ifdef DEMUX_BROADCAST_EN
  input  logic                   in_bcast,
`endif
  output logic                   in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [15:0]            xfer_count
);

  // Handshake: a word moves on any edge where valid && ready are both high.
  // in_ready never looks at in_valid; a channel is free when empty or draining now.
  logic [N_OUT-1:0] chan_free;
  logic [N_OUT-1:0] load;
  logic             accept;

  assign chan_free = ~out_valid | out_ready;

  always_comb begin
    in_ready = chan_free[in_sel];
`ifdef DEMUX_BROADCAST_EN
    if (in_bcast) in_ready = &chan_free;
`endif
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load[in_sel] = 1'b1;
`ifdef DEMUX_BROADCAST_EN
      if (in_bcast) load = '1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= '0;
      xfer_count <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        // A same-cycle load wins over delivery so the channel keeps streaming.
        if (load[i]) begin
          out_data[i*WIDTH +: WIDTH] <= in_data;
          out_valid[i]               <= 1'b1;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      if (accept) xfer_count <= xfer_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_demux16_router.sv
// Directed self-checking bench for demux16_router (unicast, plus broadcast when DEMUX_BROADCAST_EN is set).
module tb_demux16_router;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] xfer_count;
`ifdef DEMUX_BROADCAST_EN
  logic        in_bcast;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] words[4];
  logic [15:0] exp_w;

  demux16_router #(.WIDTH(16), .N_OUT(4), .SEL_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast   (in_bcast),
`endif
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] chan(input int i);
    return out_data[i*16 +: 16];
  endfunction

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = '0;
`ifdef DEMUX_BROADCAST_EN
    in_bcast  = 1'b0;
`endif
    words[0] = 16'h0000; words[1] = 16'hFFFF; words[2] = 16'h5555; words[3] = 16'hAAAA;

    // Reset then idle
    step(); step();
    reset = 1'b0;
    step();
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) check_eq($sformatf("rst_data%0d", i), 32'(chan(i)), 32'h0);
    check_eq("rst_count", 32'(xfer_count), 32'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check_eq($sformatf("idle_ready%0d", s), 32'(in_ready), 32'h1);
    end

    // Write to channel 2, then stall a second write until out_ready[2] pulses
    in_sel = 2'd2; in_data = 16'hAAAA; in_valid = 1'b1;
    step();
    in_data = 16'hBBBB;
    #1;
    check_eq("w1_valid", 32'(out_valid), 32'h4);
    check_eq("w1_data2", 32'(chan(2)), 32'hAAAA);
    check_eq("stall_ready", 32'(in_ready), 32'h0);
    step();
    check_eq("stall_data2", 32'(chan(2)), 32'hAAAA);
    check_eq("stall_count", 32'(xfer_count), 32'h1);
    in_valid = 1'b0;
    #1;
    check_eq("stall_ready_noval", 32'(in_ready), 32'h0);
    in_valid = 1'b1;
    out_ready = 4'b0100;
    #1;
    check_eq("drain_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    #1;
    check_eq("w2_data2", 32'(chan(2)), 32'hBBBB);
    check_eq("w2_valid", 32'(out_valid), 32'h4);
    check_eq("w2_count", 32'(xfer_count), 32'h2);

    // Back-to-back stream to channel 1 with consumer always ready
    out_ready = 4'b0010;
    in_sel = 2'd1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        in_data = words[k]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k < 4) check_eq($sformatf("stream_ready%0d", k), 32'(in_ready), 32'h1);
      if (out_valid[1]) begin
        if (exp_q.size() == 0) check_eq("stream_unexpected", 32'(chan(1)), 32'hDEAD);
        else begin
          exp_w = exp_q.pop_front();
          check_eq($sformatf("stream_word%0d", k), 32'(chan(1)), 32'(exp_w));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
      step();
    end
    check_eq("stream_left", 32'(exp_q.size()), 32'h0);
    check_eq("stream_valid", 32'(out_valid), 32'h4);
    check_eq("stream_count", 32'(xfer_count), 32'h6);

    // Channel 0 stalled full; channel 3 still accepts
    out_ready = 4'b0000;
    in_sel = 2'd0; in_data = 16'h1234; in_valid = 1'b1;
    step();
    in_sel = 2'd3; in_data = 16'h5555;
    #1;
    check_eq("ch3_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0; in_sel = 2'd0;
    #1;
    check_eq("ch3_data", 32'(chan(3)), 32'h5555);
    check_eq("ch0_data", 32'(chan(0)), 32'h1234);
    check_eq("ch03_valid", 32'(out_valid), 32'hD);
    check_eq("ch0_ready", 32'(in_ready), 32'h0);
    check_eq("ch2_hold", 32'(chan(2)), 32'hBBBB);
    check_eq("ch03_count", 32'(xfer_count), 32'h8);

    // out_ready on an empty channel does nothing; delivered data is not cleared
    out_ready = 4'b0010;
    step();
    out_ready = 4'b0000;
    check_eq("empty_rdy_valid", 32'(out_valid), 32'hD);
    check_eq("empty_rdy_data1", 32'(chan(1)), 32'hAAAA);

    // Fill channel 1 then reset with a word presented
    in_sel = 2'd1; in_data = 16'h1111; in_valid = 1'b1;
    step();
    reset = 1'b1; in_data = 16'h9999;
    step();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) check_eq($sformatf("mid_rst_data%0d", i), 32'(chan(i)), 32'h0);
    check_eq("mid_rst_count", 32'(xfer_count), 32'h0);

    // Counter wrap: 65535 accepts then one more
    out_ready = 4'b0001; in_sel = 2'd0; in_data = 16'h7E7E; in_valid = 1'b1;
    repeat (65535) step();
    check_eq("count_ffff", 32'(xfer_count), 32'hFFFF);
    step();
    in_valid = 1'b0;
    #1;
    check_eq("count_wrap", 32'(xfer_count), 32'h0);
    check_eq("wrap_data0", 32'(chan(0)), 32'h7E7E);

`ifdef DEMUX_BROADCAST_EN
    // Broadcast blocked by full channel 0 until it drains
    out_ready = 4'b0000;
    in_bcast = 1'b1; in_data = 16'hA5A5; in_valid = 1'b1;
    #1;
    check_eq("bcast_blocked", 32'(in_ready), 32'h0);
    out_ready = 4'b0001;
    #1;
    check_eq("bcast_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
    #1;
    for (int i = 0; i < 4; i++) check_eq($sformatf("bcast_data%0d", i), 32'(chan(i)), 32'hA5A5);
    check_eq("bcast_valid", 32'(out_valid), 32'hF);
    check_eq("bcast_count", 32'(xfer_count), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
